// File: rtl/rv_cache_pkg.sv
// Shared cache definitions: FSM state encoding, address-split width helpers
// and the 32-bit instruction selector used by the instruction cache.
package rv_cache_pkg;

  // Default geometry for the instruction cache
  localparam int unsigned ICACHE_ADDR_W = 16;
  localparam int unsigned ICACHE_LINES  = 16;
  localparam int unsigned ICACHE_WPL    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } cache_state_t;

  // Byte offset bits: 3 for the 64-bit word plus the word-within-line bits
  function automatic int unsigned off_w(input int unsigned wpl);
    return 3 + $clog2(wpl);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned lines,
                                        input int unsigned wpl);
    return addr_w - off_w(wpl) - idx_w(lines);
  endfunction

  localparam int unsigned ICACHE_OFF_W = off_w(ICACHE_WPL);
  localparam int unsigned ICACHE_IDX_W = idx_w(ICACHE_LINES);
  localparam int unsigned ICACHE_TAG_W = tag_w(ICACHE_ADDR_W, ICACHE_LINES, ICACHE_WPL);

  // pc[2] picks the upper or lower instruction of a 64-bit word
  function automatic logic [31:0] inst_sel(input logic [63:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Instruction cache data array: LINES x WPL 64-bit words.
// Ports: clk, rst (async, active-high, clears only the read register),
//        we/waddr/wdata single write port, raddr/rdata 1-cycle registered read.
// A same-cycle write to the read address is forwarded so the refill's final
// word can be delivered without an extra cycle.
module icache_line_ram #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WPL   = 4,
  parameter int unsigned AW    = $clog2(LINES * WPL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [LINES * WPL];

  // Write port; array contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read with write-first forwarding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= 64'd0;
    else     rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between Reg_PC and Reg_D.
// Ports: clk, rst (async, active-high); pc/req/flush fetch side;
//        inst/inst_valid response (valid one cycle after acceptance);
//        waiting stall request (combinational, high from miss cycle through REFILL);
//        m_rd_address/mrden/m_data/m_valid one-outstanding refill handshake.
module icache
  import rv_cache_pkg::*;
#(
  parameter int unsigned ADDR_W = ICACHE_ADDR_W,
  parameter int unsigned LINES  = ICACHE_LINES,
  parameter int unsigned WPL    = ICACHE_WPL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       pc,
  input  logic              req,
  input  logic              flush,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              waiting,
  output logic [ADDR_W-1:0] m_rd_address,
  output logic              mrden,
  input  logic [63:0]       m_data,
  input  logic              m_valid
);

  localparam int unsigned WORD_W = $clog2(WPL);
  localparam int unsigned IDX_W  = idx_w(LINES);
  localparam int unsigned OFF_W  = off_w(WPL);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, LINES, WPL);
  localparam int unsigned RAM_AW = IDX_W + WORD_W;

  // Address split of the incoming pc
  logic [WORD_W-1:0] pc_word;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  assign pc_word = pc[3 +: WORD_W];
  assign pc_idx  = pc[OFF_W +: IDX_W];
  assign pc_tag  = pc[OFF_W + IDX_W +: TAG_W];

  // pc bits above ADDR_W and the always-zero byte bits carry no information
  logic unused_pc;
  assign unused_pc = ^{pc[63:ADDR_W], pc[1:0]};

  cache_state_t      state, state_d;
  logic [TAG_W-1:0]  tag_arr [LINES];
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [WORD_W-1:0] miss_word;
  logic              miss_hi;
  logic [WORD_W-1:0] cnt;
  logic              flush_pend;
  logic              sel_q;
  logic              lookup, hit, last_beat;
  logic [63:0]       ram_rdata;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;

  // Flush overrides req: no lookup and no miss in a redirect cycle
  assign lookup    = (state == IDLE) && req && !flush;
  assign hit       = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
  assign last_beat = (state == REFILL) && m_valid && (cnt == WORD_W'(WPL - 1));

  // During REFILL the read port targets the missed word so RESPOND can deliver it
  assign ram_we    = (state == REFILL) && m_valid;
  assign ram_waddr = {miss_idx, cnt};
  assign ram_raddr = (state == REFILL) ? {miss_idx, miss_word} : {pc_idx, pc_word};

  icache_line_ram #(
    .LINES (LINES),
    .WPL   (WPL),
    .AW    (RAM_AW)
  ) u_line_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (m_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign inst = inst_sel(ram_rdata, sel_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and stall request
  always_comb begin
    state_d = state;
    waiting = 1'b0;
    case (state)
      IDLE: begin
        if (lookup && !hit) begin
          state_d = REFILL;
          waiting = 1'b1;
        end
      end
      REFILL: begin
        waiting = 1'b1;
        if (last_beat) state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Miss capture, refill sequencing, valid bits and response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      cnt          <= '0;
      mrden        <= 1'b0;
      m_rd_address <= '0;
      inst_valid   <= 1'b0;
      flush_pend   <= 1'b0;
      miss_tag     <= '0;
      miss_idx     <= '0;
      miss_word    <= '0;
      miss_hi      <= 1'b0;
      sel_q        <= 1'b0;
    end else begin
      mrden      <= 1'b0;
      inst_valid <= 1'b0;
      sel_q      <= (state == REFILL) ? miss_hi : pc[2];
      case (state)
        IDLE: begin
          if (lookup) begin
            if (hit) begin
              inst_valid <= 1'b1;
            end else begin
              miss_tag     <= pc_tag;
              miss_idx     <= pc_idx;
              miss_word    <= pc_word;
              miss_hi      <= pc[2];
              cnt          <= '0;
              flush_pend   <= 1'b0;
              mrden        <= 1'b1;
              m_rd_address <= {pc_tag, pc_idx, {WORD_W{1'b0}}, 3'b000};
            end
          end
        end
        REFILL: begin
          if (flush) flush_pend <= 1'b1;
          if (m_valid) begin
            cnt <= cnt + WORD_W'(1);
            if (last_beat) begin
              // A redirect seen at any point of the refill suppresses the response
              inst_valid <= !(flush_pend || flush);
            end else begin
              mrden        <= 1'b1;
              m_rd_address <= {miss_tag, miss_idx, cnt + WORD_W'(1), 3'b000};
            end
          end
        end
        RESPOND: valid_q[miss_idx] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Tag array has no reset; the valid bits guard it
  always_ff @(posedge clk) begin
    if (state == RESPOND) tag_arr[miss_idx] <= miss_tag;
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed fetch scenarios plus a random
// pc trace, with a latency-randomising backing memory and a scoreboard.
module tb_icache;

  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc;
  logic        req;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        waiting;
  logic [15:0] m_rd_address;
  logic        mrden;
  logic [63:0] m_data;
  logic        m_valid;

  always #5 clk = ~clk;

  icache #(.ADDR_W(16), .LINES(16), .WPL(WPL)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .req          (req),
    .flush        (flush),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .waiting      (waiting),
    .m_rd_address (m_rd_address),
    .mrden        (mrden),
    .m_data       (m_data),
    .m_valid      (m_valid)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  int          beats = 0;
  int          fixed_lat = 3;
  bit          model_valid [16];
  logic [6:0]  model_tag [16];

  // Backing memory contents: distinct per 8-byte word
  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {a, ~a, a ^ 16'h1234, 16'hBEEF + a};
  endfunction

  function automatic logic [31:0] ref_inst(input logic [63:0] a);
    logic [63:0] w;
    w = mem_word(a[15:0] & 16'hFFF8);
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Backing memory: one response per request after 1-5 cycles
  initial begin
    bit          pending = 0;
    bit          busy;
    int          cd = 0;
    logic [15:0] pa = '0;
    m_valid = 1'b0;
    m_data  = '0;
    forever begin
      @(negedge clk);
      busy    = pending;
      m_valid = 1'b0;
      if (pending) begin
        if (cd == 0) begin
          m_valid = 1'b1;
          m_data  = mem_word(pa);
          pending = 0;
          beats++;
        end else begin
          cd--;
        end
      end
      if (mrden === 1'b1) begin
        chk("one_outstanding", 64'(busy), 64'd0);
        addr_q.push_back(m_rd_address);
        pa      = m_rd_address;
        pending = 1;
        cd      = ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5))) - 1;
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst_valid actual inst=%h required no response", inst);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("inst pc=%h", e.pc), 64'(inst), 64'(e.inst));
        end
      end
    end
  end

  // Issue one fetch and hold it until the cache stops stalling
  task automatic fetch(input logic [63:0] a, input bit fl, input bit fl_mid);
    logic [3:0] idx;
    logic [6:0] tg;
    bit         miss;
    bit         done;
    idx = a[8:5];
    tg  = a[15:9];
    @(negedge clk);
    #1;
    pc    = a;
    req   = 1'b1;
    flush = fl;
    miss  = !fl && !(model_valid[idx] && model_tag[idx] == tg);
    if (!fl && !(miss && fl_mid)) exp_q.push_back('{a, ref_inst(a)});
    #1 chk($sformatf("waiting_first pc=%h", a), 64'(waiting), 64'(miss));
    if (miss) begin
      done = 0;
      for (int n = 0; n < 400 && !done; n++) begin
        @(negedge clk);
        #1;
        flush = fl_mid && (n == 1);
        #1;
        if (!waiting) done = 1;
      end
      flush = 1'b0;
      if (!done) begin
        errors++;
        $display("FAIL refill_timeout pc=%h", a);
      end
      chk("resp_valid", 64'(inst_valid), 64'(!fl_mid));
      chk("mrden_count", 64'(addr_q.size()), 64'(WPL));
      for (int i = 0; i < WPL; i++) begin
        if (addr_q.size() > 0)
          chk("mrden_addr", 64'(addr_q.pop_front()), 64'((a[15:0] & 16'hFFE0) + 16'(8 * i)));
      end
      model_valid[idx] = 1;
      model_tag[idx]   = tg;
    end
  endtask

  task automatic settle(input int n);
    @(negedge clk);
    #1;
    req   = 1'b0;
    flush = 1'b0;
    repeat (n) @(negedge clk);
    chk("no_extra_mrden", 64'(addr_q.size()), 64'd0);
    chk("responses_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int b0;
    bit fl, fm;
    logic [63:0] a;
    pc = '0;
    req = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 16; i++) model_valid[i] = 0;
    #1 rst = 1'b1;
    #3;
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_waiting", 64'(waiting), 64'd0);
    chk("rst_mrden", 64'(mrden), 64'd0);
    chk("rst_addr", 64'(m_rd_address), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Cold miss then sequential hits within the line
    fetch(64'h0, 0, 0);
    for (int i = 1; i < 8; i++) fetch(64'(4 * i), 0, 0);
    settle(8);

    // Conflict on index 0
    fetch(64'h0, 0, 0);
    fetch(64'h200, 0, 0);
    fetch(64'h0, 0, 0);
    settle(8);

    // Flush during refill installs the line silently
    fetch(64'h40, 0, 1);
    settle(4);
    fetch(64'h48, 0, 0);
    settle(4);

    // Flush in IDLE: no response on a hit, no refill on a miss
    fetch(64'h0, 1, 0);
    @(negedge clk);
    #1 chk("flush_idle_no_valid", 64'(inst_valid), 64'd0);
    fetch(64'h3000, 1, 0);
    settle(8);

    // Reset in the middle of a refill
    @(negedge clk);
    #1;
    pc  = 64'h100;
    req = 1'b1;
    #1 chk("t5_miss", 64'(waiting), 64'd1);
    b0 = beats;
    for (int n = 0; n < 200 && beats < b0 + 2; n++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #2;
    req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_inst", 64'(inst), 64'd0);
    chk("rst_mid_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_mid_waiting", 64'(waiting), 64'd0);
    chk("rst_mid_mrden", 64'(mrden), 64'd0);
    chk("rst_mid_addr", 64'(m_rd_address), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) model_valid[i] = 0;
    repeat (10) @(negedge clk);
    addr_q.delete();
    settle(4);
    fetch(64'h100, 0, 0);
    settle(8);

    // Random trace with random memory latency
    fixed_lat = 0;
    for (int k = 0; k < 200; k++) begin
      a = {$urandom, $urandom};
      a[15:0] = 16'($urandom_range(0, 16'h7FF)) & 16'hFFFC;
      fl = ($urandom_range(0, 9) == 0);
      fm = ($urandom_range(0, 7) == 0);
      fetch(a, fl, fm);
    end
    settle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
